// File: rtl/cam_pkg.sv
// Shared camera-path constants: output frame geometry, RGB444 field slices, FSM encoding.
package cam_pkg;
  localparam int OUT_WIDTH    = 320;
  localparam int OUT_HEIGHT   = 240;
  localparam int FRAME_PIXELS = OUT_WIDTH * OUT_HEIGHT;

  localparam int NUM_CH = 3;
  localparam int CH_W   = 4;
  localparam int HSUM_W = CH_W + 1;
  localparam int VSUM_W = CH_W + 2;

  localparam int R_MSB = 11, R_LSB = 8;
  localparam int G_MSB = 7,  G_LSB = 4;
  localparam int B_MSB = 3,  B_LSB = 0;

  typedef enum logic [1:0] {IDLE = 2'd0, ACTIVE = 2'd1, DONE = 2'd2} state_t;

  // channel index 0=B, 1=G, 2=R so a packed [NUM_CH-1:0][CH_W-1:0] matches pixel layout
  function automatic int ch_msb(input int ch);
    return (ch == 2) ? R_MSB : (ch == 1) ? G_MSB : B_MSB;
  endfunction

  function automatic int ch_lsb(input int ch);
    return (ch == 2) ? R_LSB : (ch == 1) ? G_LSB : B_LSB;
  endfunction
endpackage

// File: rtl/line_buffer_sdp.sv
// Simple dual-port line RAM holding even-row horizontal sums; registered read that holds
// its value until the next read enable so gapped odd-row pixels still see the right entry.
module line_buffer_sdp #(
  parameter int DEPTH = 320,
  parameter int W     = 15,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data
);
  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/rgb444_downscale_2x2.sv
// 2x2 box-filter decimator: RGB444 camera stream in, one averaged pixel per 2x2 block
// written to the frame buffer RAM port A.
module rgb444_downscale_2x2
  import cam_pkg::*;
#(
  parameter int IN_WIDTH  = 2 * OUT_WIDTH,
  parameter int IN_HEIGHT = 2 * OUT_HEIGHT,
  parameter int ADDR_W    = $clog2(FRAME_PIXELS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_start,
  input  logic              pixel_valid,
  input  logic [11:0]       pixel_data,
  input  logic              line_end,
  output logic [11:0]       save_data,
  output logic [ADDR_W-1:0] save_address,
  output logic              write_enable,
  output logic              frame_done,
  output logic              overflow_err
);
  localparam int OUT_W     = IN_WIDTH / 2;
  localparam int LAST_ADDR = (IN_WIDTH / 2) * (IN_HEIGHT / 2) - 1;
  localparam int COL_W     = $clog2(IN_WIDTH + 1);
  localparam int ROW_W     = $clog2(IN_HEIGHT + 1);
  localparam int LB_AW     = $clog2(OUT_W);

  state_t               state;
  logic [COL_W-1:0]     col;
  logic [ROW_W-1:0]     row;
  logic [ADDR_W-1:0]    addr;

  logic [NUM_CH-1:0][CH_W-1:0]   pix_ch, h_latch, out_ch;
  logic [NUM_CH-1:0][HSUM_W-1:0] hsum, lb_rd;

  logic in_frame, take, ovf, emit, lb_wr, lb_rd_en;
  logic [LB_AW-1:0] lb_addr;

  // frame_start wins over everything, so the coincident pixel is never taken
  assign in_frame = (state == ACTIVE) && !frame_start && (row < ROW_W'(IN_HEIGHT));
  assign take     = in_frame && pixel_valid && (col < COL_W'(IN_WIDTH));
  assign ovf      = in_frame && pixel_valid && !(col < COL_W'(IN_WIDTH));
  assign emit     = take &&  col[0] &&  row[0];
  assign lb_wr    = take &&  col[0] && !row[0];
  assign lb_rd_en = take && !col[0] &&  row[0];
  assign lb_addr  = LB_AW'(col >> 1);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    localparam int MSB = ch_msb(c);
    localparam int LSB = ch_lsb(c);
    assign pix_ch[c] = pixel_data[MSB:LSB];
    assign hsum[c]   = HSUM_W'(h_latch[c]) + HSUM_W'(pix_ch[c]);
    // round half up; the 6-bit sum tops out at 62 so no saturation is needed
    assign out_ch[c] = CH_W'((VSUM_W'(hsum[c]) + VSUM_W'(lb_rd[c]) + VSUM_W'(2)) >> 2);
  end

  line_buffer_sdp #(.DEPTH(OUT_W), .W(NUM_CH * HSUM_W), .AW(LB_AW)) u_lb (
    .clk     (clk),
    .wr_en   (lb_wr),
    .wr_addr (lb_addr),
    .wr_data (hsum),
    .rd_en   (lb_rd_en),
    .rd_addr (lb_addr),
    .rd_data (lb_rd)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      col          <= '0;
      row          <= '0;
      addr         <= '0;
      h_latch      <= '0;
      save_data    <= '0;
      save_address <= '0;
      write_enable <= 1'b0;
      frame_done   <= 1'b0;
      overflow_err <= 1'b0;
    end else begin
      write_enable <= 1'b0;
      frame_done   <= 1'b0;
      if (frame_start) begin
        state        <= ACTIVE;
        col          <= '0;
        row          <= '0;
        addr         <= '0;
        overflow_err <= 1'b0;
      end else if (state == ACTIVE) begin
        if (take) begin
          col <= col + COL_W'(1);
          if (!col[0]) h_latch <= pix_ch;
        end
        if (ovf) overflow_err <= 1'b1;
        if (emit) begin
          write_enable <= 1'b1;
          save_data    <= out_ch;
          save_address <= addr;
          addr         <= addr + ADDR_W'(1);
          if (addr == ADDR_W'(LAST_ADDR)) begin
            frame_done <= 1'b1;
            state      <= DONE;
          end
        end
        // a pixel on the same cycle was already counted above; line_end then closes the line
        if (line_end && (row < ROW_W'(IN_HEIGHT))) begin
          col <= '0;
          row <= row + ROW_W'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_rgb444_downscale_2x2.sv
// Directed bench for the 2x2 decimator on a reduced 16x8 frame; a frame-level averaging
// model feeds an expectation queue that a negedge compare process drains.
module tb_rgb444_downscale_2x2;
  localparam int W    = 16;
  localparam int H    = 8;
  localparam int LAST = (W / 2) * (H / 2) - 1;
  localparam int MAXL = H + 2;
  localparam int MAXC = W + 10;

  logic        clk = 1'b0, reset = 1'b1;
  logic        frame_start = 1'b0, pixel_valid = 1'b0, line_end = 1'b0;
  logic [11:0] pixel_data = '0;
  logic [11:0] save_data;
  logic [16:0] save_address;
  logic        write_enable, frame_done, overflow_err;

  rgb444_downscale_2x2 #(.IN_WIDTH(W), .IN_HEIGHT(H), .ADDR_W(17)) dut (
    .clk          (clk),
    .reset        (reset),
    .frame_start  (frame_start),
    .pixel_valid  (pixel_valid),
    .pixel_data   (pixel_data),
    .line_end     (line_end),
    .save_data    (save_data),
    .save_address (save_address),
    .write_enable (write_enable),
    .frame_done   (frame_done),
    .overflow_err (overflow_err)
  );

  always #5 clk = ~clk;

  typedef struct {logic [11:0] d; int a;} exp_t;
  exp_t exp_q[$];

  int n_vec = 0, n_err = 0;
  int n_writes = 0, n_done = 0, last_done_addr = -1, first_waddr = -1;
  logic [11:0] first_wdata = '0;
  bit started = 0;
  logic [11:0] pix [MAXL][MAXC];
  int len [MAXL];
  int m_addr = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic logic [11:0] avg4(input logic [11:0] a, b, c, d);
    logic [11:0] r;
    int s;
    for (int ch = 0; ch < 3; ch++) begin
      s = int'(a[ch*4 +: 4]) + int'(b[ch*4 +: 4]) + int'(c[ch*4 +: 4]) + int'(d[ch*4 +: 4]);
      r[ch*4 +: 4] = 4'((s + 2) / 4);
    end
    return r;
  endfunction

  // Expected writes for the first nlines lines: each row pair yields one pixel per
  // complete column pair of the odd row (capped at W), addresses run on until LAST.
  task automatic model_frame(input int nlines);
    exp_t e;
    int n;
    for (int p = 0; 2*p + 1 < nlines && 2*p + 1 < H; p++) begin
      n = ((len[2*p+1] < W) ? len[2*p+1] : W) / 2;
      for (int c = 0; c < n; c++) begin
        if (m_addr <= LAST) begin
          e.d = avg4(pix[2*p][2*c], pix[2*p][2*c+1], pix[2*p+1][2*c], pix[2*p+1][2*c+1]);
          e.a = m_addr;
          exp_q.push_back(e);
        end
        m_addr++;
      end
    end
  endtask

  always @(negedge clk) begin : cmp
    exp_t e;
    if (started) begin
      if (write_enable === 1'b1) begin
        n_writes++;
        if (n_writes == 1) begin
          first_wdata = save_data;
          first_waddr = int'(save_address);
        end
        if (exp_q.size() == 0) check("unexpected_write", 32'(save_address), 32'hFFFF_FFFF);
        else begin
          e = exp_q.pop_front();
          check("save_data", 32'(save_data), 32'(e.d));
          check("save_address", 32'(save_address), 32'(e.a));
          check("frame_done_on_write", 32'(frame_done), 32'(e.a == LAST));
        end
        if (frame_done === 1'b1) begin
          n_done++;
          last_done_addr = int'(save_address);
        end
      end else
        check("frame_done_idle", 32'(frame_done), 32'd0);
    end
  end

  task automatic tick(input logic fs, input logic pv, input logic [11:0] pd, input logic le);
    frame_start = fs; pixel_valid = pv; pixel_data = pd; line_end = le;
    @(posedge clk); #1;
    frame_start = 0; pixel_valid = 0; pixel_data = '0; line_end = 0;
  endtask

  // Odd lines end with line_end on the last pixel, even lines with a separate pulse.
  task automatic drive_frame(input int nlines, input bit start, input bit gap, input bit last_le);
    bit le_here, coin;
    if (start) begin
      m_addr = 0;
      model_frame(nlines);
      tick(1, 1, 12'hFFF, 0);
    end
    for (int r = 0; r < nlines; r++) begin
      le_here = (r < nlines - 1) || last_le;
      coin    = (r % 2 == 1) && le_here && (len[r] > 0);
      for (int i = 0; i < len[r]; i++) begin
        if (gap) repeat ($urandom_range(1)) tick(0, 0, '0, 0);
        tick(0, 1, pix[r][i], coin && (i == len[r] - 1));
      end
      if (le_here && !coin) tick(0, 0, '0, 1);
    end
  endtask

  task automatic drain(input string name);
    int k = 0;
    repeat (2) tick(0, 0, '0, 0);
    while (exp_q.size() != 0 && k < 50) begin
      tick(0, 0, '0, 0);
      k++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic fill(input bit flat);
    for (int r = 0; r < MAXL; r++) begin
      len[r] = W;
      for (int c = 0; c < MAXC; c++) pix[r][c] = flat ? 12'hA5C : 12'($urandom);
    end
  endtask

  task automatic new_test();
    n_writes = 0; n_done = 0; last_done_addr = -1; first_waddr = -1;
  endtask

  task automatic check_reset_outputs();
    check("rst_write_enable", 32'(write_enable), 32'd0);
    check("rst_save_data", 32'(save_data), 32'd0);
    check("rst_save_address", 32'(save_address), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_overflow_err", 32'(overflow_err), 32'd0);
  endtask

  initial begin
    tick(0, 0, '0, 0);
    started = 1;
    tick(0, 0, '0, 0);
    check_reset_outputs();
    reset = 0;

    // idle: pixels without frame_start produce nothing
    fill(0); new_test();
    drive_frame(2, 0, 0, 1);
    drain("idle_drain");
    check("idle_writes", 32'(n_writes), 32'd0);

    // flat frame, then lines after DONE are ignored
    fill(1); new_test();
    drive_frame(H, 1, 0, 1);
    drain("flat_drain");
    check("flat_first_data", 32'(first_wdata), 32'hA5C);
    check("flat_writes", 32'(n_writes), 32'(LAST + 1));
    check("flat_done_count", 32'(n_done), 32'd1);
    check("flat_done_addr", 32'(last_done_addr), 32'd31);
    drive_frame(2, 0, 0, 1);
    drain("after_done_drain");
    check("after_done_writes", 32'(n_writes), 32'(LAST + 1));

    // rounding block at address 0
    fill(0); new_test();
    pix[0][0] = 12'h01F; pix[0][1] = 12'h01F;
    pix[1][0] = 12'h01F; pix[1][1] = 12'h20F;
    drive_frame(H, 1, 0, 1);
    drain("round_drain");
    check("round_data", 32'(first_wdata), 32'h11F);
    check("round_addr", 32'(first_waddr), 32'd0);

    // gapped stream
    fill(0); new_test();
    drive_frame(H, 1, 1, 1);
    drain("gap_drain");
    check("gap_writes", 32'(n_writes), 32'(LAST + 1));
    check("gap_done_count", 32'(n_done), 32'd1);

    // mid-frame restart: 3 full lines + 5 pixels of line 3, then a fresh frame
    fill(0); new_test();
    len[3] = 5;
    drive_frame(4, 1, 0, 0);
    drain("abort_drain");
    check("abort_writes", 32'(n_writes), 32'(W / 2 + 2));
    check("abort_done_count", 32'(n_done), 32'd0);
    fill(0); new_test();
    drive_frame(H, 1, 0, 1);
    drain("restart_drain");
    check("restart_first_addr", 32'(first_waddr), 32'd0);
    check("restart_done_count", 32'(n_done), 32'd1);

    // overlong lines: 26 and 17 pixels on the first row pair
    fill(0); new_test();
    len[0] = W + 10; len[1] = W + 1;
    drive_frame(H, 1, 0, 1);
    drain("ovf_drain");
    check("ovf_sticky", 32'(overflow_err), 32'd1);
    check("ovf_writes", 32'(n_writes), 32'(LAST + 1));
    tick(1, 0, '0, 0);
    check("ovf_cleared", 32'(overflow_err), 32'd0);

    // odd-length row pair drops its trailing pixel; lines past H are ignored
    fill(0); new_test();
    len[2] = W - 1; len[3] = W - 1;
    drive_frame(H + 2, 1, 0, 1);
    drain("odd_drain");
    check("odd_writes", 32'(n_writes), 32'(LAST));
    check("odd_done_count", 32'(n_done), 32'd0);
    check("odd_no_ovf", 32'(overflow_err), 32'd0);

    // reset mid-frame
    fill(0); new_test();
    drive_frame(5, 1, 0, 0);
    drain("pre_reset_drain");
    reset = 1;
    tick(0, 0, '0, 0);
    reset = 0;
    check_reset_outputs();
    new_test();
    drive_frame(2, 0, 0, 1);
    drain("post_reset_idle_drain");
    check("post_reset_idle_writes", 32'(n_writes), 32'd0);
    fill(0); new_test();
    drive_frame(H, 1, 0, 1);
    drain("post_reset_drain");
    check("post_reset_done_count", 32'(n_done), 32'd1);
    check("post_reset_first_addr", 32'(first_waddr), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
